fc_mac_sequencer: RTL and testbench
===================================

Name: fc_mac_sequencer

Overview:
- Time-multiplexed controller for the fully connected forward pass: one 16x16 multiply-accumulate unit replaces the fully parallel MAC array.
- Walks output neurons i = 0..OUT_SIZE-1 and inputs j = 0..IN_SIZE-1, driving read addresses into synchronous input, weight and bias memories.
- Accumulates each neuron's sum, adds its bias and presents the result on a valid/ready output stream.
- Sits between the activation/weight buffers and the downstream loss or activation stage.

Parameters:
- IN_SIZE, 120, number of input activations
- OUT_SIZE, 10, number of output neurons
- DATA_W, 16, width of input, weight and bias words
- ACC_W, 32, accumulator and output width

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a layer pass; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the pass completes
- mem_rd_en  output  1  read strobe shared by all three memories
- in_addr  output  clog2(IN_SIZE)  input activation index j
- w_addr  output  clog2(IN_SIZE*OUT_SIZE)  weight address = j*OUT_SIZE + i
- b_addr  output  clog2(OUT_SIZE)  bias index i
- in_data  input  DATA_W  activation read data, valid 1 cycle after mem_rd_en
- w_data  input  DATA_W  weight read data, valid 1 cycle after mem_rd_en
- b_data  input  DATA_W  bias read data, valid 1 cycle after mem_rd_en
- out_valid  output  1  result available
- out_idx  output  clog2(OUT_SIZE)  neuron index of the result
- out_data  output  ACC_W  result = sum + bias
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready

Behaviour:
- Reset values: state IDLE; busy, done, mem_rd_en and out_valid = 0; all addresses, out_idx, out_data, counters and accumulator = 0.
- States: IDLE, ACCUM, WRITE, FINISH.
- IDLE: on start=1, go to ACCUM with i=0, j=0, acc=0.
- ACCUM, issue phase:
  - While j < IN_SIZE, assert mem_rd_en with in_addr=j, w_addr=j*OUT_SIZE+i, b_addr=i, then j++.
  - Registered issue-valid flag delays accumulate by one cycle: acc <= acc + in_data*w_data.
  - b_data is captured into a bias register on the first returned beat (j==0 beat).
- ACCUM, drain: ACCUM lasts exactly IN_SIZE+1 cycles; the last cycle only accumulates, with mem_rd_en=0. Then go to WRITE.
- WRITE:
  - out_valid=1, out_idx=i, out_data = acc + zero-extended bias.
  - out_data and out_idx are held stable until out_ready.
  - On the handshake: if i==OUT_SIZE-1 go to FINISH; else i++, j=0, acc=0, go to ACCUM.
- FINISH: done=1 for one cycle, busy still 1, then IDLE.
- Arithmetic: unsigned; product is 2*DATA_W bits, zero-extended to ACC_W; all sums wrap modulo 2^ACC_W with no saturation.
- Latency: with out_ready tied high, each neuron takes IN_SIZE+2 cycles. done is asserted in cycle OUT_SIZE*(IN_SIZE+2)+1 after the start-sampling edge.
- start while busy: ignored, no restart, no queuing.
- start in the same cycle as FINISH: ignored; it must be re-asserted in IDLE.
- out_ready deasserted: stall in WRITE indefinitely; no memory reads are issued while stalled.
- Reset mid-pass: immediate return to reset values, partial results discarded, no done pulse.
- Boundaries: j counts 0..IN_SIZE-1, and w_addr never exceeds IN_SIZE*OUT_SIZE-1. IN_SIZE=1 and OUT_SIZE=1 must work.

Decomposition:
- Shared package fc_pkg: state enum (IDLE, ACCUM, WRITE, FINISH), default DATA_W/ACC_W constants, clog2 helper.
- One sub-module, fc_mac_unit: registered multiply-accumulate with clear, enable and ACC_W wrap. The sequencer owns all counters, the FSM and the output register.

Test Plan:
- IN=4, OUT=3, x={1,2,3,4}, w[j][i]=j+i, bias={5,6,7}, out_ready=1 -> outputs (idx,data) = (0,25), (1,36), (2,47); done pulses exactly 19 cycles after the start edge.
- Same config, x and w all 0xFFFF, bias 0 -> each out_data=0xFFF80004, showing modulo-2^32 wrap.
- out_ready held low 5 cycles on neuron 1 -> out_valid, out_idx=1 and out_data=36 stable; mem_rd_en=0 during the stall; done delayed by 5 cycles.
- start pulsed again mid-pass and on the FINISH cycle -> no restart and exactly one done; a new start in IDLE repeats the sequence identically.
- rst asserted in ACCUM of neuron 2 -> all outputs 0 immediately, state IDLE, no done; a following start produces the full correct result set.
- Address check over the whole pass -> w_addr sequence is i, OUT+i, 2*OUT+i, 3*OUT+i per neuron, and never reaches 12.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_pkg : shared types and helpers for the fully connected MAC sequencer   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } fc_state_e;

    localparam int FC_DATA_W = 16;
    localparam int FC_ACC_W  = 32;

    // Never returns less than 1 so single-entry memories still get a 1-bit address.
    function automatic int fc_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_mac_unit : registered unsigned multiply-accumulate, clear and enable   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int ACC_W  = FC_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc_next
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;

    assign prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The sequencer needs the post-edge value to latch the result in the drain cycle.
    assign o_acc_next = acc_d;

endmodule
`default_nettype wire

// File: rtl/fc_mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fc_mac_sequencer : time-multiplexed fully connected layer using one MAC   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fc_mac_sequencer
    import fc_pkg::*;
#(
    parameter int IN_SIZE  = 120,
    parameter int OUT_SIZE = 10,
    parameter int DATA_W   = FC_DATA_W,
    parameter int ACC_W    = FC_ACC_W,
    localparam int IAW     = fc_clog2(IN_SIZE),
    localparam int WAW     = fc_clog2(IN_SIZE * OUT_SIZE),
    localparam int BAW     = fc_clog2(OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [IAW-1:0]    in_addr,
    output logic [WAW-1:0]    w_addr,
    output logic [BAW-1:0]    b_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    output logic [BAW-1:0]    out_idx,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready
);

    localparam int             JW     = fc_clog2(IN_SIZE + 1);
    localparam logic [JW-1:0]  J_END  = JW'(IN_SIZE);
    localparam logic [JW-1:0]  J_LAST = JW'(IN_SIZE - 1);
    localparam logic [BAW-1:0] I_LAST = BAW'(OUT_SIZE - 1);
    localparam logic [WAW-1:0] W_STEP = WAW'(OUT_SIZE);

    fc_state_e          state_q, state_d;
    logic [BAW-1:0]     i_q, i_d;
    logic [JW-1:0]      j_q, j_d;
    logic [WAW-1:0]     wp_q, wp_d;
    logic               iv_q, iv_d;
    logic               first_q, first_d;
    logic [DATA_W-1:0]  bias_q, bias_d;
    logic               out_valid_q, out_valid_d;
    logic [BAW-1:0]     out_idx_q, out_idx_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;

    logic               issue;
    logic               mac_clear;
    logic [BAW-1:0]     i_inc;
    logic [ACC_W-1:0]   acc_next;

    fc_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (mac_clear),
        .i_en       (iv_q),
        .i_a        (in_data),
        .i_b        (w_data),
        .o_acc_next (acc_next)
    );

    assign i_inc   = i_q + BAW'(1);
    assign iv_d    = issue;
    assign first_d = issue && (j_q == '0);
    // With IN_SIZE=1 the bias beat lands in the same cycle the result is latched.
    assign bias_d  = first_q ? b_data : bias_q;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        wp_d        = wp_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        mac_clear   = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    i_d       = '0;
                    j_d       = '0;
                    wp_d      = '0;
                    mac_clear = 1'b1;
                end
            end
            ACCUM: begin
                if (j_q != J_END) begin
                    issue = 1'b1;
                    j_d   = j_q + JW'(1);
                    // Weight pointer stops at the last row so it never leaves the array.
                    if (j_q != J_LAST) begin
                        wp_d = wp_q + W_STEP;
                    end
                end else begin
                    state_d     = WRITE;
                    out_valid_d = 1'b1;
                    out_idx_d   = i_q;
                    out_data_d  = acc_next + ACC_W'(bias_d);
                end
            end
            WRITE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (i_q == I_LAST) begin
                        state_d = FINISH;
                    end else begin
                        state_d   = ACCUM;
                        i_d       = i_inc;
                        j_d       = '0;
                        wp_d      = WAW'(i_inc);
                        mac_clear = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            wp_q        <= '0;
            iv_q        <= 1'b0;
            first_q     <= 1'b0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            wp_q        <= wp_d;
            iv_q        <= iv_d;
            first_q     <= first_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign mem_rd_en = issue;
    assign in_addr   = issue ? IAW'(j_q) : '0;
    assign w_addr    = issue ? wp_q : '0;
    assign b_addr    = issue ? i_q : '0;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fc_mac_sequencer : directed bench with scoreboard for fc_mac_sequencer |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fc_mac_sequencer;

    localparam int IN  = 4;
    localparam int OUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [1:0]  in_addr;
    logic [3:0]  w_addr;
    logic [1:0]  b_addr;
    logic [15:0] in_data = '0;
    logic [15:0] w_data  = '0;
    logic [15:0] b_data  = '0;
    logic        out_valid;
    logic [1:0]  out_idx;
    logic [31:0] out_data;
    logic        out_ready;

    logic [15:0] x_mem [0:IN-1];
    logic [15:0] w_mem [0:IN*OUT-1];
    logic [15:0] b_mem [0:OUT-1];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int done_cnt  = 0;
    int rd_cnt    = 0;
    int exp_idx[$];
    int exp_data[$];

    fc_mac_sequencer #(
        .IN_SIZE  (IN),
        .OUT_SIZE (OUT),
        .DATA_W   (16),
        .ACC_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .b_addr    (b_addr),
        .in_data   (in_data),
        .w_data    (w_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories: one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            in_data <= x_mem[in_addr];
            w_data  <= w_mem[w_addr];
            b_data  <= b_mem[b_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int i);
        logic [31:0] s;
        s = 32'd0;
        for (int j = 0; j < IN; j++) begin
            s = s + 32'(x_mem[j]) * 32'(w_mem[j*OUT+i]);
        end
        return s + 32'(b_mem[i]);
    endfunction

    task automatic push_expected();
        for (int i = 0; i < OUT; i++) begin
            exp_idx.push_back(i);
            exp_data.push_back(int'(model(i)));
        end
    endtask

    task automatic load_plan1();
        for (int j = 0; j < IN; j++) begin
            x_mem[j] = 16'(j + 1);
            for (int i = 0; i < OUT; i++) w_mem[j*OUT+i] = 16'(j + i);
        end
        for (int i = 0; i < OUT; i++) b_mem[i] = 16'(i + 5);
    endtask

    task automatic load_ones();
        for (int j = 0; j < IN; j++) begin
            x_mem[j] = 16'hFFFF;
            for (int i = 0; i < OUT; i++) w_mem[j*OUT+i] = 16'hFFFF;
        end
        for (int i = 0; i < OUT; i++) b_mem[i] = 16'h0000;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt, prev + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_in_addr"}, in_addr, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // Read-address monitor: reads in a pass run neuron-major, input-minor.
    always @(negedge clk) begin
        if (!busy) begin
            rd_cnt = 0;
        end else if (mem_rd_en) begin
            check("rd_in_addr", in_addr, rd_cnt % IN);
            check("rd_b_addr", b_addr, rd_cnt / IN);
            check("rd_w_addr", w_addr, (rd_cnt % IN) * OUT + rd_cnt / IN);
            check("rd_w_range", w_addr < IN*OUT, 1);
            rd_cnt++;
        end
    end

    // Output scoreboard and done tracker.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", exp_idx.size() != 0, 1);
            if (exp_idx.size() != 0) begin
                check("out_idx", out_idx, exp_idx.pop_front());
                check("out_data", out_data, exp_data.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        load_plan1();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Basic pass.
        push_expected();
        prev = done_cnt;
        do_start();
        wait_done(prev);
        check("A_done_cycle", done_cyc - start_cyc + 1, 19);
        @(negedge clk);
        check("A_done_pulse", done, 0);
        check("A_idle", busy, 0);
        check("A_drained", exp_idx.size(), 0);

        // Wrap-around pass.
        load_ones();
        push_expected();
        prev = done_cnt;
        do_start();
        wait_done(prev);
        check("B_done_cycle", done_cyc - start_cyc + 1, 19);
        @(negedge clk);
        check("B_drained", exp_idx.size(), 0);

        // Backpressure on neuron 1.
        load_plan1();
        push_expected();
        prev = done_cnt;
        do_start();
        n = 0;
        while (!(mem_rd_en && b_addr == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("C_reach_n1", n < 100, 1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("C_reach_write", n < 100, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("C_stall_valid", out_valid, 1);
            check("C_stall_idx", out_idx, 1);
            check("C_stall_data", out_data, 36);
            check("C_stall_rd_en", mem_rd_en, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(prev);
        check("C_done_cycle", done_cyc - start_cyc + 1, 24);
        @(negedge clk);
        check("C_drained", exp_idx.size(), 0);

        // start pulses mid-pass and during FINISH must be ignored.
        push_expected();
        prev = done_cnt;
        do_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("D_one_done", done_cnt, prev + 1);
        check("D_done_cycle", done_cyc - start_cyc + 1, 19);
        check("D_idle", busy, 0);
        check("D_drained", exp_idx.size(), 0);

        // Fresh start repeats the sequence.
        push_expected();
        prev = done_cnt;
        do_start();
        wait_done(prev);
        check("E_done_cycle", done_cyc - start_cyc + 1, 19);
        @(negedge clk);
        check("E_drained", exp_idx.size(), 0);

        // Reset while accumulating neuron 2.
        push_expected();
        prev = done_cnt;
        do_start();
        n = 0;
        while (!(mem_rd_en && b_addr == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("F_reach_n2", n < 100, 1);
        rst = 1'b1;
        #1;
        check_all_zero("F_rst");
        exp_idx.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("F_no_done", done_cnt, prev);
        check("F_idle", busy, 0);

        // Full pass after the abort.
        push_expected();
        prev = done_cnt;
        do_start();
        wait_done(prev);
        check("G_done_cycle", done_cyc - start_cyc + 1, 19);
        @(negedge clk);
        check("G_drained", exp_idx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
